// File: rtl/vic_irq_responder_pkg.sv
// Shared types for the VIC IRQ responder: FSM state encoding, nesting stack entry
// and default vector-table geometry.
package vic_irq_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_TAKE    = 2'd2,
        ST_SERVICE = 2'd3
    } irq_state_e;

    typedef struct packed {
        logic [3:0] num;
        logic       nv;
    } irq_entry_t;

    localparam int NV_OFFSET_DEFAULT   = 'h40;
    localparam int ENTRY_SHIFT_DEFAULT = 2;

    // A non-vectored request always carries handler number 0.
    function automatic irq_entry_t make_entry(input logic [3:0] num, input logic nv);
        irq_entry_t e;
        e.num = nv ? 4'd0 : num;
        e.nv  = nv;
        return e;
    endfunction

endpackage

// File: rtl/vic_irq_responder_nest_stack.sv
// LIFO of preempted handlers {num, nv}; used by vic_irq_responder only when
// VIC_IRQ_NEST_EN is defined.
module vic_irq_responder_nest_stack
    import vic_irq_responder_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  irq_entry_t push_data,
    output irq_entry_t top_data,
    output logic       full,
    output logic       empty,
    output logic [2:0] count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    irq_entry_t mem [DEPTH];
    logic [2:0] count_q;
    logic [2:0] top_idx;

    assign full    = (count_q == 3'(DEPTH));
    assign empty   = (count_q == 3'd0);
    assign count   = count_q;
    assign top_idx = count_q - 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 3'd0;
        end else if (push && !full) begin
            count_q <= count_q + 3'd1;
        end else if (pop && !empty) begin
            count_q <= count_q - 3'd1;
        end
    end

    // NOTE: storage is deliberately not reset; count_q gates every read, so stale
    // entries are never observed and the array can map to plain flops or RAM.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count_q[IW-1:0]] <= push_data;
        end
    end

    assign top_data = empty ? '0 : mem[top_idx[IW-1:0]];

endmodule

// File: rtl/vic_irq_responder.sv
// CPU-side end of the VIC request interface: waits for an instruction boundary,
// redirects fetch to the handler vector, acks the source and tracks service until
// RETI. Define VIC_IRQ_NEST_EN to enable preemption with a nesting stack.
module vic_irq_responder
    import vic_irq_responder_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int ENTRY_SHIFT = ENTRY_SHIFT_DEFAULT,
    parameter int NV_OFFSET   = NV_OFFSET_DEFAULT,
    parameter int NEST_DEPTH  = 4   // must be >= 2 when nesting is enabled
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              irq_req,
    input  logic [3:0]        irq_handler_num,
    input  logic              irq_is_nv,
    input  logic              irq_global_en,
    input  logic              insn_boundary,
    input  logic              reti,
    input  logic [ADDR_W-1:0] vector_base,
    output logic              cpu_irq_take,
    output logic [ADDR_W-1:0] cpu_irq_pc,
    output logic              irq_ack,
    output logic [3:0]        irq_ack_num,
    output logic              irq_ack_is_nv,
    output logic              irq_active,
    output logic [3:0]        irq_active_num,
    output logic [2:0]        nest_depth
);

    irq_state_e state_q, state_d;
    irq_entry_t cur_q, cur_d;
    irq_entry_t arb_entry;
    logic       req_ok;
    logic       take;
    logic       in_service;
    logic [ADDR_W-1:0] entry_offset;

    assign req_ok    = irq_req & irq_global_en;
    assign arb_entry = make_entry(irq_handler_num, irq_is_nv);

`ifdef VIC_IRQ_NEST_EN
    logic       stk_push, stk_pop, stk_full, stk_empty;
    logic [2:0] stk_count;
    irq_entry_t stk_top;
    logic       preempts;

    // Lower number wins; any vectored request beats the non-vectored one.
    assign preempts = !irq_is_nv && (cur_q.nv || (irq_handler_num < cur_q.num));

    vic_irq_responder_nest_stack #(
        .DEPTH (NEST_DEPTH - 1)
    ) u_nest_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (cur_q),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .count     (stk_count)
    );
`endif

    // NOTE: sequential state uses non-blocking assignments so every register in the
    // design samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no branch can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
`ifdef VIC_IRQ_NEST_EN
        stk_push = 1'b0;
        stk_pop  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_ok) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (!req_ok) begin
                    state_d = ST_IDLE;
`ifdef VIC_IRQ_NEST_EN
                    // Withdrawn preemption resumes the interrupted handler.
                    if (!stk_empty) begin
                        stk_pop = 1'b1;
                        cur_d   = stk_top;
                        state_d = ST_SERVICE;
                    end
`endif
                end else if (insn_boundary) begin
                    cur_d   = arb_entry;
                    state_d = ST_TAKE;
                end
            end
            ST_TAKE: begin
                state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (reti) begin
                    state_d = ST_IDLE;
`ifdef VIC_IRQ_NEST_EN
                    if (!stk_empty) begin
                        stk_pop = 1'b1;
                        cur_d   = stk_top;
                        state_d = ST_SERVICE;
                    end
                end else if (req_ok && preempts && !stk_full) begin
                    stk_push = 1'b1;
                    state_d  = ST_PEND;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign take       = (state_q == ST_TAKE);
    assign in_service = (state_q == ST_SERVICE);

    // Vector arithmetic wraps modulo 2^ADDR_W by construction.
    assign entry_offset = cur_q.nv ? ADDR_W'(NV_OFFSET)
                                   : (ADDR_W'(cur_q.num) << ENTRY_SHIFT);

    assign cpu_irq_take   = take;
    assign cpu_irq_pc     = take ? (vector_base + entry_offset) : '0;
    assign irq_ack        = take;
    assign irq_ack_num    = take ? cur_q.num : 4'd0;
    assign irq_ack_is_nv  = take & cur_q.nv;
    assign irq_active     = in_service;
    assign irq_active_num = in_service ? cur_q.num : 4'd0;

`ifdef VIC_IRQ_NEST_EN
    assign nest_depth = stk_count + {2'b00, in_service};
`else
    assign nest_depth = (in_service && NEST_DEPTH > 0) ? 3'd1 : 3'd0;
`endif

endmodule
